// File: rtl/irq_ctrl_pkg.sv
// Shared types and register offsets for the interrupt controller.
// Optional feature macro: IRQ_CTRL_SW_TRIGGER_EN (software trigger register ISWR).
package irq_ctrl_pkg;

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ID_W   = 5;

    localparam logic [ADDR_W-1:0] IRQ_CTRL_IER_OFFSET  = 12'h000;
    localparam logic [ADDR_W-1:0] IRQ_CTRL_IPR_OFFSET  = 12'h004;
    localparam logic [ADDR_W-1:0] IRQ_CTRL_ISR_OFFSET  = 12'h008;
    localparam logic [ADDR_W-1:0] IRQ_CTRL_IVR_OFFSET  = 12'h00C;
    localparam logic [ADDR_W-1:0] IRQ_CTRL_ITR_OFFSET  = 12'h010;
    localparam logic [ADDR_W-1:0] IRQ_CTRL_ISWR_OFFSET = 12'h014;

    typedef enum logic [2:0] {
        REG_IER,
        REG_IPR,
        REG_ISR,
        REG_IVR,
        REG_ITR,
        REG_ISWR,
        REG_NONE
    } irq_ctrl_reg_t;

    typedef struct packed {
        logic        valid;
        logic [25:0] res;
        logic [4:0]  id;
    } irq_ctrl_ivr_t;

    // Map a byte offset to a register select; ISWR only exists with the trigger feature.
    function automatic irq_ctrl_reg_t irq_ctrl_decode(input logic [ADDR_W-1:0] addr);
        irq_ctrl_reg_t sel;
        case (addr)
            IRQ_CTRL_IER_OFFSET:  sel = REG_IER;
            IRQ_CTRL_IPR_OFFSET:  sel = REG_IPR;
            IRQ_CTRL_ISR_OFFSET:  sel = REG_ISR;
            IRQ_CTRL_IVR_OFFSET:  sel = REG_IVR;
            IRQ_CTRL_ITR_OFFSET:  sel = REG_ITR;
`ifdef IRQ_CTRL_SW_TRIGGER_EN
            IRQ_CTRL_ISWR_OFFSET: sel = REG_ISWR;
`endif
            default:              sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder over the active interrupt vector.
module irq_ctrl_prio_enc
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = 8
) (
    input  logic [N_SRC-1:0] vec,
    output logic             valid,
    output logic [ID_W-1:0]  id
);

    // Scan from the top down so the lowest set index is the last one written.
    always_comb begin
        valid = |vec;
        id    = '0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (vec[i]) begin
                id = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/irq_ctrl.sv
// Interrupt controller: latches source events as pending, masks them and drives a
// registered level interrupt to the core; register access over the peripheral bus.
// Optional feature macro: IRQ_CTRL_SW_TRIGGER_EN adds the write-only ISWR at 0x014.
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int unsigned N_SRC = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SRC-1:0]  src_i,
    input  logic              req,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              gnt,
    output logic              rvalid,
    output logic [DATA_W-1:0] rdata,
    output logic              irq_o
);

    logic [N_SRC-1:0] ier;
    logic [N_SRC-1:0] ipr;
    logic [N_SRC-1:0] itr;
    logic [N_SRC-1:0] src_q;
    logic [N_SRC-1:0] isr;
    logic [N_SRC-1:0] set_evt;
    logic [N_SRC-1:0] clr;
    logic [N_SRC-1:0] sw_set;
    logic [N_SRC-1:0] wbits;
    logic             isr_any;
    logic [ID_W-1:0]  isr_id;
    irq_ctrl_ivr_t    ivr;
    irq_ctrl_reg_t    sel;
    logic             wr;
    logic             rd;
    logic [DATA_W-1:0] rd_val;
    logic             unused_wdata;

    assign gnt          = req;
    assign sel          = irq_ctrl_decode(addr);
    assign wr           = req & we;
    assign rd           = req & ~we;
    assign wbits        = wdata[N_SRC-1:0];
    assign unused_wdata = ^wdata;
    assign isr          = ipr & ier;

    irq_ctrl_prio_enc #(
        .N_SRC (N_SRC)
    ) u_prio_enc (
        .vec   (isr),
        .valid (isr_any),
        .id    (isr_id)
    );

    // Vector register image; id is already zero when nothing is active.
    always_comb begin
        ivr       = '0;
        ivr.valid = isr_any;
        ivr.id    = isr_id;
    end

    // Pending-bit set/clear terms; a set in the same cycle as a clear wins.
    always_comb begin
        clr = '0;
        if (wr && (sel == REG_IPR)) begin
            clr = wbits;
        end
`ifdef IRQ_CTRL_SW_TRIGGER_EN
        sw_set = '0;
        if (wr && (sel == REG_ISWR)) begin
            sw_set = wbits;
        end
`else
        sw_set = '0;
`endif
        set_evt = (src_i & itr) | (src_i & ~src_q & ~itr) | sw_set;
    end

    // Read mux; write-only and unmapped offsets read as zero.
    always_comb begin
        rd_val = '0;
        case (sel)
            REG_IER: rd_val = DATA_W'(ier);
            REG_IPR: rd_val = DATA_W'(ipr);
            REG_ISR: rd_val = DATA_W'(isr);
            REG_IVR: rd_val = ivr;
            REG_ITR: rd_val = DATA_W'(itr);
            default: rd_val = '0;
        endcase
    end

    // Configuration, source history and pending state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ier   <= '0;
            itr   <= '0;
            ipr   <= '0;
            src_q <= '0;
        end else begin
            src_q <= src_i;
            ipr   <= (ipr & ~clr) | set_evt;
            if (wr && (sel == REG_IER)) begin
                ier <= wbits;
            end
            if (wr && (sel == REG_ITR)) begin
                itr <= wbits;
            end
        end
    end

    // Bus response: one-cycle-later valid; data only for reads, zero otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= req;
            rdata  <= rd ? rd_val : '0;
        end
    end

    // Registered interrupt request from the masked pending set.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_o <= 1'b0;
        end else begin
            irq_o <= isr_any;
        end
    end

endmodule

// File: doc/irq_ctrl.md
Name: irq_ctrl

Overview:
- Interrupt controller downstream of the timer and the other SoC peripherals.
- Collects up to 32 event lines (e.g. the timer's match/overflow pulse), latches them as pending, masks them and drives a single registered interrupt request to the core.
- Software accesses it through the standard 12-bit-offset peripheral bus slave interface.
- Provides a priority-encoded vector register: lowest source index wins.

Parameters:
- N_SRC, 8, number of interrupt sources (1..32); bits above N_SRC-1 in every register read 0 and ignore writes.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- src_i  input  N_SRC  interrupt source lines, synchronous to clk
- req  input  1  bus request
- we  input  1  write enable (1 = write)
- addr  input  12  register byte offset
- wdata  input  32  write data
- gnt  output  1  bus grant
- rvalid  output  1  read/write response valid
- rdata  output  32  read data
- irq_o  output  1  interrupt request to core, level

Behaviour:
- Reset (asynchronous, rst=1), all zero: IER, IPR, ITR, src_q, irq_o, rvalid, rdata.
- Register map (offset, access):
  - IER 0x000 RW, per-source enable.
  - IPR 0x004 RW1C, pending; writing 1 clears the bit, writing 0 has no effect.
  - ISR 0x008 RO, IPR & IER.
  - IVR 0x00C RO: bit31 = |ISR; bits[4:0] = lowest set index of ISR; all other bits 0. When ISR is 0, IVR reads 0. Reading has no side effect.
  - ITR 0x010 RW, per-source trigger: 0 = rising edge, 1 = level-high.
- Bus:
  - gnt = req, combinational, every cycle.
  - rvalid asserts exactly one cycle after any granted access, read or write.
  - rdata is registered and valid while rvalid=1.
  - Writes take effect at the grant edge.
  - Unmapped offsets: reads return 0, writes are ignored.
  - rdata is 0 when rvalid=0.
- Source sampling: src_q <= src_i every cycle.
  - Edge source: set_evt = src_i & ~src_q.
  - Level source: set_evt = src_i.
- Pending update per bit, each cycle: IPR <= (IPR & ~clr) | set_evt.
  - A set and a clear in the same cycle: set wins, so the bit stays 1.
  - A level source held high therefore cannot be cleared until it drops.
  - Pending bits latch regardless of IER, so masked events are not lost.
- irq_o <= |(IPR & IER), registered.
  - Latency: for an edge source rising before edge n, IPR is set at edge n and irq_o asserts at edge n+1.
  - A W1C that clears the last active bit deasserts irq_o one edge after the write edge.
- Changing ITR from level to edge does not clear the pending bit.
- Enabling IER while IPR is already set asserts irq_o on the next edge.
- A new pulse on an already-pending source merges into the existing pending bit; there is no counting.
- An assertion of rst mid-transaction aborts it: rvalid drops immediately and no register retains partial state.

Optional Feature:
- IRQ_CTRL_SW_TRIGGER_EN.
- When defined: adds register ISWR at 0x014, write-only (reads 0). Writing 1 to bit k ORs into set_evt for one cycle, setting IPR[k]. Priority vs. a simultaneous W1C is the same as hardware: set wins. Used for software-raised interrupts and self-test.
- When undefined: offset 0x014 is unmapped and set_evt comes only from src_i.

Decomposition:
- irq_ctrl_pkg holds:
  - offset macros IRQ_CTRL_IER_OFFSET..IRQ_CTRL_ISWR_OFFSET;
  - enum irq_ctrl_reg_t (IER, IPR, ISR, IVR, ITR, ISWR, NONE);
  - packed struct irq_ctrl_ivr_t (valid, res[25:0], id[4:0]).
- One sub-module, irq_ctrl_prio_enc: combinational N_SRC-wide lowest-index-first encoder producing the valid flag and id[4:0]. It is used both for IVR and for the irq_o OR.

Test Plan:
- Reset then read all registers -> rdata 0 for each; irq_o=0; rvalid pulses one cycle after each req.
- IER=0x01, ITR=0, one-cycle pulse on src_i[0] -> IPR=0x01 next edge, irq_o=1 one edge later; IVR reads 0x80000000; writing IPR=0x01 drops irq_o one edge after the write.
- IER=0x00, pulse src_i[3], then write IER=0x08 -> irq_o asserts the edge after the IER write; ISR=0x08; IVR=0x80000003.
- ITR=0x04, IER=0x04, hold src_i[2]=1, write IPR=0x04 -> IPR stays 0x04 and irq_o stays 1; drop src_i[2], write IPR=0x04 -> IPR=0, irq_o=0.
- Sources 5 and 1 pending and enabled together -> IVR=0x80000001; after clearing bit 1, IVR=0x80000005.
- With IRQ_CTRL_SW_TRIGGER_EN defined, IER=0x80, write ISWR=0x80 -> IPR=0x80 and irq_o=1. Without the macro, the same write leaves IPR=0 and a read of 0x014 returns 0.
